// File: rtl/ss_mac_frame_if.sv
// Handshake and data bundle for ss_mac_frame: frame control, sample stream and result.
// master = frame driver / sample source, slave = ss_mac_frame.
interface ss_mac_frame_if #(
    parameter int IN_W   = 12,
    parameter int SS_W   = 4,
    parameter int RAND_W = IN_W - SS_W,
    parameter int LEN_W  = 10,
    parameter int ACC_W  = 2 * SS_W + LEN_W
);
    // Valid/ready: a sample moves on a rising edge where in_valid and in_ready
    // are both high; in_valid may drop at any time and in_ready never depends on
    // in_valid. start is a level sampled on the edge, acted on only in IDLE/DONE.
    logic              start;
    logic [LEN_W-1:0]  frame_len;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   x_input;
    logic [IN_W-1:0]   y_input;
    logic [RAND_W-1:0] x_randnum;
    logic [RAND_W-1:0] y_randnum;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  z_output;
    logic [1:0]        dbg_state;

    modport master (
        output start, frame_len, in_valid, x_input, y_input, x_randnum, y_randnum,
        input  in_ready, busy, done, z_output, dbg_state
    );

    modport slave (
        input  start, frame_len, in_valid, x_input, y_input, x_randnum, y_randnum,
        output in_ready, busy, done, z_output, dbg_state
    );
endinterface

// File: rtl/ss_mac_frame.sv
// Framed stochastic-symbol multiply-accumulate: stochastic rounding of two streams,
// symbol product, accumulation over frame_len samples. Optional macro: SS_MAC_PIPE_EN.
module ss_mac_frame #(
    parameter int IN_W   = 12,
    parameter int SS_W   = 4,
    parameter int RAND_W = IN_W - SS_W,
    parameter int LEN_W  = 10,
    parameter int ACC_W  = 2 * SS_W + LEN_W
) (
    input logic           clk,
    input logic           rst,
    ss_mac_frame_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count;
    logic [ACC_W-1:0]  acc;
    logic              done_q;
    logic [SS_W-1:0]   sym_x;
    logic [SS_W-1:0]   sym_y;
    logic [2*SS_W-1:0] product;
    logic [2*SS_W-1:0] add_val;
    logic              add_en;
    logic              accept;
    logic              last;

    // Round up when the fraction beats the random number; an integer part
    // already at full scale stays there instead of wrapping to zero.
    function automatic logic [SS_W-1:0] to_sym(input logic [IN_W-1:0] v,
                                               input logic [RAND_W-1:0] r);
        logic [SS_W-1:0]   i;
        logic [RAND_W-1:0] f;
        i = v[IN_W-1:RAND_W];
        f = v[RAND_W-1:0];
        if ((f > r) && (i != {SS_W{1'b1}}))
            return i + SS_W'(1);
        else
            return i;
    endfunction

    assign sym_x   = to_sym(bus.x_input, bus.x_randnum);
    assign sym_y   = to_sym(bus.y_input, bus.y_randnum);
    assign product = {{SS_W{1'b0}}, sym_x} * {{SS_W{1'b0}}, sym_y};
    assign accept  = bus.in_valid && (state == S_RUN);
    assign last    = (count == (len_q - LEN_W'(1)));

`ifdef SS_MAC_PIPE_EN
    logic [2*SS_W-1:0] prod_q;
    logic              prod_v;

    assign add_val = prod_q;
    assign add_en  = prod_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            prod_v <= 1'b0;
        end else begin
            prod_q <= product;
            prod_v <= accept;
        end
    end
`else
    assign add_val = product;
    assign add_en  = accept;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            len_q  <= '0;
            count  <= '0;
            acc    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (add_en)
                acc <= acc + {{(ACC_W-2*SS_W){1'b0}}, add_val};
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        acc   <= '0;
                        len_q <= bus.frame_len;
                        count <= '0;
                        if (bus.frame_len == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        count <= count + LEN_W'(1);
                        if (last) begin
`ifdef SS_MAC_PIPE_EN
                            state  <= S_DRAIN;
`else
                            state  <= S_DONE;
                            done_q <= 1'b1;
`endif
                        end
                    end
                end
                S_DRAIN: begin
                    // Last product is being added on this edge.
                    state  <= S_DONE;
                    done_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_RUN);
    assign bus.busy      = (state == S_RUN) || (state == S_DRAIN);
    assign bus.done      = done_q;
    assign bus.z_output  = acc;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_ss_mac_frame.sv
// Self-checking bench for ss_mac_frame: frame results queued as stimulus is driven,
// compared when done pulses; covers reset, rounding, saturation, gaps, zero length.
module tb_ss_mac_frame;
    localparam int IN_W   = 12;
    localparam int SS_W   = 4;
    localparam int RAND_W = 8;
    localparam int LEN_W  = 10;
    localparam int ACC_W  = 18;
`ifdef SS_MAC_PIPE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ss_mac_frame_if #(.IN_W(IN_W), .SS_W(SS_W), .RAND_W(RAND_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

    ss_mac_frame #(.IN_W(IN_W), .SS_W(SS_W), .RAND_W(RAND_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int exp_frames = 0;
    int last_edge = 0;
    int exp_acc = 0;
    logic [ACC_W-1:0] last_z = '0;
    logic [ACC_W-1:0] exp_q[$];
    int lat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_sym(input int v, input int r);
        int s;
        s = (v / 256) + (((v % 256) > r) ? 1 : 0);
        return (s > 15) ? 15 : s;
    endfunction

    // Scoreboard: every done pulse must match the oldest queued frame.
    always @(negedge clk) begin
        logic [ACC_W-1:0] e;
        int l;
        if (!rst && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("z_final", 32'(bus.z_output), 32'(e));
                check("done_latency", 32'(cyc - last_edge), 32'(l));
                last_z = e;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int len, input bit with_valid);
        bus.start     = 1'b1;
        bus.frame_len = len[LEN_W-1:0];
        bus.in_valid  = with_valid;
        bus.x_input   = 12'hFFF;
        bus.y_input   = 12'hFFF;
        tick();
        last_edge    = cyc;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        exp_acc      = 0;
        if (len == 0) begin
            exp_q.push_back('0);
            lat_q.push_back(0);
            exp_frames++;
        end
    endtask

    task automatic send(input int x, input int y, input int xr, input int yr);
        bit ok;
        ok = 1'b0;
        bus.x_input   = x[IN_W-1:0];
        bus.y_input   = y[IN_W-1:0];
        bus.x_randnum = xr[RAND_W-1:0];
        bus.y_randnum = yr[RAND_W-1:0];
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        tick();
        last_edge    = cyc;
        bus.in_valid = 1'b0;
        exp_acc     += model_sym(x, xr) * model_sym(y, yr);
    endtask

    task automatic finish_frame();
        exp_q.push_back(exp_acc[ACC_W-1:0]);
        lat_q.push_back(LAT);
        exp_frames++;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20; k++) begin
            if (done_cnt >= exp_frames) break;
            tick();
        end
        check("done_seen", 32'(done_cnt), 32'(exp_frames));
        @(negedge clk);
        check("z_held", 32'(bus.z_output), 32'(last_z));
        check("done_single", 32'(bus.done), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.frame_len = '0; bus.in_valid = 1'b0;
        bus.x_input = '0; bus.y_input = '0; bus.x_randnum = '0; bus.y_randnum = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_z", 32'(bus.z_output), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        tick();

        // Deterministic: 3*2 per sample over 4 samples.
        start_frame(4, 1'b0);
        check("run_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 4; i++) send(12'h300, 12'h200, $urandom_range(0, 255), $urandom_range(0, 255));
        check("det_model", 32'(exp_acc), 32'd24);
        finish_frame();
        wait_done();

        // Stochastic rounding, with a sample offered alongside start (not taken).
        start_frame(2, 1'b1);
        send(12'h380, 12'h100, 8'h10, 8'hFF);
        send(12'h380, 12'h100, 8'h90, 8'hFF);
        check("stoch_model", 32'(exp_acc), 32'd7);
        finish_frame();
        wait_done();

        // Full-scale saturation over the longest frame.
        start_frame(1023, 1'b0);
        for (int i = 0; i < 1023; i++) send(12'hFFF, 12'hFFF, 0, 0);
        check("sat_model", 32'(exp_acc), 32'd230175);
        finish_frame();
        wait_done();

        // Valid gaps with a start pulse mid-frame.
        start_frame(3, 1'b0);
        send(12'h250, 12'h1C0, 8'h40, 8'h80);
        bus.start = 1'b1;
        bus.frame_len = 10'd7;
        tick();
        bus.start = 1'b0;
        send(12'h5A0, 12'h2F0, 8'hA0, 8'h10);
        tick();
        send(12'h0FF, 12'hE01, 8'h00, 8'h00);
        finish_frame();
        wait_done();

        // Zero-length frame.
        start_frame(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("zl_in_ready", 32'(bus.in_ready), 32'd0);
        end
        tick();
        wait_done();

        // Random frames with random gaps.
        for (int f = 0; f < 3; f++) begin
            int len;
            len = $urandom_range(1, 20);
            start_frame(len, 1'b0);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send($urandom_range(0, 4095), $urandom_range(0, 4095),
                     $urandom_range(0, 255), $urandom_range(0, 255));
            end
            finish_frame();
            wait_done();
        end

        // Reset mid-frame: abandoned, no done.
        start_frame(5, 1'b0);
        send(12'h300, 12'h300, 0, 0);
        send(12'h300, 12'h300, 0, 0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_z", 32'(bus.z_output), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        tick();
        rst = 1'b0;
        repeat (10) tick();

        check("done_count", 32'(done_cnt), 32'(exp_frames));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
